// File: rtl/adder_share_arbiter.sv
// Shares one external 8-bit combinational adder between two valid/ready requesters.
// A transaction runs IDLE (grant) -> ADD (drive adder) -> RESP (hold sum until taken).
module adder_share_arbiter #(
  parameter bit          FIXED_PRIORITY = 1'b0,
  parameter int unsigned COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [7:0]         req0_a,
  input  logic [7:0]         req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [7:0]         req1_a,
  input  logic [7:0]         req1_b,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic [7:0]         resp0_sum,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [7:0]         resp1_sum,
  output logic [7:0]         adder_a,
  output logic [7:0]         adder_b,
  input  logic [7:0]         adder_s,
  output logic               busy,
  output logic [COUNT_W-1:0] done0_cnt,
  output logic [COUNT_W-1:0] done1_cnt
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                ptr_q, ptr_d;
  logic [DATA_W-1:0]   adder_a_q, adder_a_d;
  logic [DATA_W-1:0]   adder_b_q, adder_b_d;
  logic                resp0_valid_q, resp0_valid_d;
  logic                resp1_valid_q, resp1_valid_d;
  logic [DATA_W-1:0]   resp0_sum_q, resp0_sum_d;
  logic [DATA_W-1:0]   resp1_sum_q, resp1_sum_d;
  logic                busy_q, busy_d;
  logic [COUNT_W-1:0]  done0_cnt_q, done0_cnt_d;
  logic [COUNT_W-1:0]  done1_cnt_q, done1_cnt_d;

  logic                grant_vld_c;
  logic                grant_id_c;
  logic                resp_hs_c;

  // Grant: a lone valid wins; on a tie the pointer (or requester 0) wins. Held off in reset.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = 1'b0;
    if (rst_n && (state_q == ST_IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant_vld_c = 1'b1;
        grant_id_c  = FIXED_PRIORITY ? 1'b0 : ptr_q;
      end else if (req0_valid) begin
        grant_vld_c = 1'b1;
        grant_id_c  = 1'b0;
      end else if (req1_valid) begin
        grant_vld_c = 1'b1;
        grant_id_c  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld_c && !grant_id_c;
  assign req1_ready = grant_vld_c &&  grant_id_c;

  // Only the owner's resp_ready counts, and only while a response is presented.
  assign resp_hs_c = (state_q == ST_RESP) && (owner_q ? resp1_ready : resp0_ready);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    adder_a_d     = '0;
    adder_b_d     = '0;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;
    resp0_sum_d   = resp0_sum_q;
    resp1_sum_d   = resp1_sum_q;
    done0_cnt_d   = done0_cnt_q;
    done1_cnt_d   = done1_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld_c) begin
          state_d   = ST_ADD;
          owner_d   = grant_id_c;
          // The adder operand registers double as the operand latch for the ADD cycle.
          adder_a_d = grant_id_c ? req1_a : req0_a;
          adder_b_d = grant_id_c ? req1_b : req0_b;
        end
      end
      ST_ADD: begin
        state_d = ST_RESP;
        if (owner_q) begin
          resp1_sum_d   = adder_s;
          resp1_valid_d = 1'b1;
        end else begin
          resp0_sum_d   = adder_s;
          resp0_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_hs_c) begin
          state_d       = ST_IDLE;
          ptr_d         = ~owner_q;
          resp0_valid_d = 1'b0;
          resp1_valid_d = 1'b0;
          if (owner_q) begin
            done1_cnt_d = done1_cnt_q + COUNT_W'(1);
          end else begin
            done0_cnt_d = done0_cnt_q + COUNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      ptr_q         <= 1'b0;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_sum_q   <= '0;
      resp1_sum_q   <= '0;
      busy_q        <= 1'b0;
      done0_cnt_q   <= '0;
      done1_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_sum_q   <= resp0_sum_d;
      resp1_sum_q   <= resp1_sum_d;
      busy_q        <= busy_d;
      done0_cnt_q   <= done0_cnt_d;
      done1_cnt_q   <= done1_cnt_d;
    end
  end

  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_sum   = resp0_sum_q;
  assign resp1_sum   = resp1_sum_q;
  assign busy        = busy_q;
  assign done0_cnt   = done0_cnt_q;
  assign done1_cnt   = done1_cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by shared stimulus.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        resp0_ready, resp1_ready;

  logic        r_req0_ready, r_req1_ready, r_resp0_valid, r_resp1_valid, r_busy;
  logic [7:0]  r_resp0_sum, r_resp1_sum, r_adder_a, r_adder_b, r_adder_s;
  logic [15:0] r_done0_cnt, r_done1_cnt;

  logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid, f_busy;
  logic [7:0]  f_resp0_sum, f_resp1_sum, f_adder_a, f_adder_b, f_adder_s;
  logic [15:0] f_done0_cnt, f_done1_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // External shared adders: sum mod 256.
  assign r_adder_s = r_adder_a + r_adder_b;
  assign f_adder_s = f_adder_a + f_adder_b;

  adder_share_arbiter #(.FIXED_PRIORITY(1'b0), .COUNT_W(16)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(r_resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(r_resp0_sum),
    .resp1_valid(r_resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(r_resp1_sum),
    .adder_a(r_adder_a), .adder_b(r_adder_b), .adder_s(r_adder_s),
    .busy(r_busy), .done0_cnt(r_done0_cnt), .done1_cnt(r_done1_cnt)
  );

  adder_share_arbiter #(.FIXED_PRIORITY(1'b1), .COUNT_W(16)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(f_resp0_sum),
    .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(f_resp1_sum),
    .adder_a(f_adder_a), .adder_b(f_adder_b), .adder_s(f_adder_s),
    .busy(f_busy), .done0_cnt(f_done0_cnt), .done1_cnt(f_done1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h33; req1_b = 8'h44;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Reset with both valids high: everything reads zero.
    tick(); tick();
    chk("rst_req0_ready", r_req0_ready, 0);
    chk("rst_req1_ready", r_req1_ready, 0);
    chk("rst_resp0_valid", r_resp0_valid, 0);
    chk("rst_resp1_valid", r_resp1_valid, 0);
    chk("rst_resp0_sum", r_resp0_sum, 0);
    chk("rst_resp1_sum", r_resp1_sum, 0);
    chk("rst_adder_a", r_adder_a, 0);
    chk("rst_adder_b", r_adder_b, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_done0", r_done0_cnt, 0);
    chk("rst_done1", r_done1_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_req0_ready", r_req0_ready, 1);
    chk("rel_req1_ready", r_req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single op on requester 0: 0x25 + 0x13 = 0x38.
    tick();
    req0_valid = 1'b1; req0_a = 8'h25; req0_b = 8'h13; resp0_ready = 1'b1;
    #1;
    chk("s_accept_ready", r_req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("s_add_a", r_adder_a, 8'h25);
    chk("s_add_b", r_adder_b, 8'h13);
    chk("s_add_busy", r_busy, 1);
    chk("s_add_resp_valid", r_resp0_valid, 0);
    chk("s_add_ready", r_req0_ready, 0);
    tick();
    chk("s_resp_valid", r_resp0_valid, 1);
    chk("s_resp_sum", r_resp0_sum, 8'h38);
    chk("s_resp_adder_a", r_adder_a, 0);
    chk("s_resp_nonowner", r_resp1_valid, 0);
    tick();
    chk("s_done_valid", r_resp0_valid, 0);
    chk("s_done_cnt0", r_done0_cnt, 1);
    chk("s_done_busy", r_busy, 0);
    chk("s_done_sum_held", r_resp0_sum, 8'h38);

    // Wrap on requester 1: 0xF0 + 0x20 = 0x10, then 0xFF + 0x01 = 0x00.
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h20; resp1_ready = 1'b1;
    #1;
    chk("w1_ready", r_req1_ready, 1);
    tick(); req1_valid = 1'b0;
    tick();
    chk("w1_valid", r_resp1_valid, 1);
    chk("w1_sum", r_resp1_sum, 8'h10);
    chk("w1_other_valid", r_resp0_valid, 0);
    tick();
    chk("w1_cnt1", r_done1_cnt, 1);
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
    #1;
    chk("w2_ready", r_req1_ready, 1);
    tick(); req1_valid = 1'b0;
    tick();
    chk("w2_valid", r_resp1_valid, 1);
    chk("w2_sum", r_resp1_sum, 8'h00);
    tick();
    chk("w2_cnt1", r_done1_cnt, 2);

    // Backpressure on requester 0; requester 1 waits and its resp_ready is ignored.
    req0_valid = 1'b1; req0_a = 8'h25; req0_b = 8'h13; resp0_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h02;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", r_resp0_valid, 1);
      chk("bp_sum", r_resp0_sum, 8'h38);
      chk("bp_busy", r_busy, 1);
      chk("bp_req1_ready", r_req1_ready, 0);
      chk("bp_cnt0", r_done0_cnt, 1);
      tick();
    end
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    tick();
    chk("bp_rel_valid", r_resp0_valid, 0);
    chk("bp_rel_cnt0", r_done0_cnt, 2);
    chk("bp_rel_busy", r_busy, 0);
    chk("bp_rel_req1_ready", r_req1_ready, 1);

    // Requester 1 transaction interrupted by reset while in RESP.
    tick(); req1_valid = 1'b0;
    tick();
    chk("mr_valid", r_resp1_valid, 1);
    chk("mr_sum", r_resp1_sum, 8'h42);
    rst_n = 1'b0;
    tick();
    chk("mr_valid_after", r_resp1_valid, 0);
    chk("mr_cnt1", r_done1_cnt, 0);
    chk("mr_cnt0", r_done0_cnt, 0);
    chk("mr_busy", r_busy, 0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h80; req0_b = 8'h90; req1_a = 8'h11; req1_b = 8'h22;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    chk("mr_ptr_req0", r_req0_ready, 1);
    chk("mr_ptr_req1", r_req1_ready, 0);

    // Contention: round-robin alternates, fixed priority always picks requester 0.
    for (int t = 0; t < 6; t++) begin
      chk("c_rr_req0", r_req0_ready, (t % 2 == 0) ? 1 : 0);
      chk("c_rr_req1", r_req1_ready, (t % 2 == 1) ? 1 : 0);
      chk("c_fp_req0", f_req0_ready, 1);
      chk("c_fp_req1", f_req1_ready, 0);
      tick(); tick(); tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("c_rr_cnt0", r_done0_cnt, 3);
    chk("c_rr_cnt1", r_done1_cnt, 3);
    chk("c_fp_cnt0", f_done0_cnt, 6);
    chk("c_fp_cnt1", f_done1_cnt, 0);
    chk("c_rr_sum0", r_resp0_sum, 8'h10);
    chk("c_rr_sum1", r_resp1_sum, 8'h33);
    chk("c_fp_sum1", f_resp1_sum, 8'h00);
    tick();
    chk("c_end_busy", r_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
